band_sum_engine: RTL
====================

BAND_SUM_ENGINE -- requirements
Module: band_sum_engine

Interface
REQ-001 The block SHALL have parameter NUM_BANDS, default 10, giving the number of band inputs (legal range 1..16).
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the signed band and sum sample width (legal range 8..24).
REQ-003 Clk  in  1  the single clock; all state SHALL update on the rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 PSel, PEnable, PWrite  in  1 each  APB control.
REQ-006 PAddr  in  12  APB address.
REQ-007 PWData  in  32  APB write data.
REQ-008 PRData  out  32  APB read data, combinational from PAddr during the read access phase, otherwise 0.
REQ-009 BandData  in  NUM_BANDS*DATA_W  packed signed band results; band i occupies bits [i*DATA_W +: DATA_W].
REQ-010 BandValid  in  NUM_BANDS  one-cycle strobe per band marking BandData slice i valid.
REQ-011 SumData  out  DATA_W  signed combined sample, held until the next result.
REQ-012 SumValid  out  1  one-cycle strobe marking a new SumData.
REQ-013 Busy  out  1  high while the state is SUM or DONE.

Function
REQ-014 Write strobe SHALL be PSel&PEnable&PWrite; read strobe SHALL be PSel&PEnable&~PWrite.
REQ-015 Register map:
- 0x00 CTRL (RW): bit0 EN; bit1 SAT (1 = saturate, 0 = wrap).
- 0x04 MASK (RW): bits[NUM_BANDS-1:0] band enables.
- 0x08 RESULT (RO): bit31 READY, bit30 OVF, bits[29:0] SumData sign-extended.
- 0x0C STATUS (RO): bits[NUM_BANDS-1:0] captured-band mask, bit30 sticky LATE, bit31 sticky DUP.
- Other addresses SHALL read 0; writes to them SHALL be ignored.
REQ-016 States SHALL be IDLE, COLLECT, SUM and DONE.
REQ-017 IDLE->COLLECT SHALL occur when EN=1 and MASK≠0; the active mask SHALL be shadowed from MASK on that transition.
REQ-018 MASK writes during COLLECT, SUM or DONE SHALL affect only the next frame.
REQ-019 In COLLECT, BandValid[i] for an active band SHALL latch slice i and set captured bit i.
REQ-020 BandValid for inactive bands SHALL be ignored.
REQ-021 BandValid[i] with captured bit i already set SHALL overwrite the latched value and set DUP.
REQ-022 COLLECT->SUM SHALL occur on the edge where captured|active-valids equals the active mask, including valids in that same cycle.
REQ-023 SUM SHALL last exactly NUM_BANDS cycles, adding one band per cycle in index order; inactive bands contribute 0.
REQ-024 The accumulator SHALL be DATA_W+clog2(NUM_BANDS) bits signed, so no intermediate overflow occurs.
REQ-025 After SUM, the result SHALL be reduced to DATA_W bits:
- SAT=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- SAT=0: keep the low DATA_W bits.
- OVF SHALL be set if the full result is out of range, in either mode.
REQ-026 DONE SHALL last one cycle; on entering DONE, SumData, OVF and READY=1 SHALL update and SumValid SHALL pulse.
REQ-027 DONE->COLLECT SHALL occur if EN=1 and MASK≠0, otherwise DONE->IDLE; captured bits SHALL clear on leaving DONE.
REQ-028 Latency: with the final valid sampled at edge E, SumValid SHALL be high from edge E+NUM_BANDS+1 for exactly one cycle.
REQ-029 BandValid during SUM or DONE SHALL be dropped and SHALL set LATE.
REQ-030 A RESULT read SHALL clear READY, unless a new result is written in the same cycle, in which case READY SHALL stay 1.
REQ-031 A STATUS read SHALL clear DUP and LATE; a flag event in the same cycle SHALL win.
REQ-032 EN cleared during COLLECT SHALL return the block to IDLE next edge and discard captures.
REQ-033 EN cleared during SUM or DONE SHALL let the frame complete, then go to IDLE.

Reset
REQ-034 Reset SHALL asynchronously force the following to 0:
- state = IDLE;
- CTRL, MASK, shadow mask and captured bits;
- latched band data and accumulator;
- SumData, SumValid, Busy, READY, OVF, DUP and LATE.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no SumValid; operation resumes only after software re-enables.

Verification
REQ-036 NUM_BANDS=10, MASK=0x3FF, EN=1, bands 0..9 = 100 each, all valid in one cycle -> SumData=1000, OVF=0, SumValid at E+11.
REQ-037 MASK=0x01F, bands 0..4 = 10000, SAT=1 -> SumData=32767, OVF=1; same stimulus with SAT=0 -> SumData=-15536, OVF=1.
REQ-038 MASK=0x003, band0=5 then band0=7 then band1=1 -> SumData=8, DUP=1; STATUS read returns bit31=1, then reads 0.
REQ-039 BandValid during SUM -> LATE=1, SumData unaffected; RESULT read in the SumValid cycle -> READY stays 1.
REQ-040 Reset pulsed while Busy=1 -> all outputs 0 immediately, no SumValid afterwards, PRData at 0x00 and 0x04 reads 0.

Source files
------------

// File: rtl/band_sum_engine.sv
// Purpose: collects masked signed band samples per frame, adds them in index order, reduces to DATA_W (wrap or saturate).
// Latency: final band valid at edge E -> SumData/SumValid registered at edge E+NUM_BANDS+1.
// Backpressure: none; band valids arriving while a frame is summing are dropped and flagged LATE.
module band_sum_engine #(
  parameter int NUM_BANDS = 10,
  parameter int DATA_W    = 16
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          PSel,
  input  logic                          PEnable,
  input  logic                          PWrite,
  input  logic [11:0]                   PAddr,
  input  logic [31:0]                   PWData,
  output logic [31:0]                   PRData,
  input  logic [NUM_BANDS*DATA_W-1:0]   BandData,
  input  logic [NUM_BANDS-1:0]          BandValid,
  output logic signed [DATA_W-1:0]      SumData,
  output logic                          SumValid,
  output logic                          Busy
);

  localparam int CNT_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int ACC_W = DATA_W + $clog2(NUM_BANDS);
  localparam int TOP_W = ACC_W - DATA_W + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, SUM, DONE} state_t;

  state_t state, state_nxt;

  logic                              en, sat;
  logic [NUM_BANDS-1:0]              mask, active, captured, hit;
  logic [NUM_BANDS-1:0][DATA_W-1:0]  band_lat;
  logic [CNT_W-1:0]                  cnt;
  logic signed [ACC_W-1:0]           acc, addend;
  logic                              ready, ovf, dup, late;
  logic                              wr, rd, wr_ctrl, wr_mask, rd_result, rd_status;
  logic                              frame_ok, sum_last, dup_evt, late_evt;
  logic [TOP_W-1:0]                  top;
  logic                              ovf_nxt;
  logic [DATA_W-1:0]                 sum_red;
  logic                              unused_pwdata;

  assign wr        = PSel & PEnable & PWrite;
  assign rd        = PSel & PEnable & ~PWrite;
  assign wr_ctrl   = wr && (PAddr == 12'h000);
  assign wr_mask   = wr && (PAddr == 12'h004);
  assign rd_result = rd && (PAddr == 12'h008);
  assign rd_status = rd && (PAddr == 12'h00C);

  // Only the low CTRL/MASK bits are architected; the rest of the write word is don't-care.
  assign unused_pwdata = ^PWData;

  assign hit      = BandValid & active;
  assign frame_ok = en && (mask != '0);
  assign sum_last = (cnt == CNT_W'(NUM_BANDS - 1));
  assign dup_evt  = (state == COLLECT) && en && ((hit & captured) != '0);
  assign late_evt = ((state == SUM) || (state == DONE)) && (BandValid != '0);

  // Next-state and Busy decode; EN only aborts a frame that is still collecting.
  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    case (state)
      IDLE: begin
        if (frame_ok) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (!en)                              state_nxt = IDLE;
        else if ((captured | hit) == active)  state_nxt = SUM;
      end
      SUM: begin
        Busy = 1'b1;
        if (sum_last) state_nxt = DONE;
      end
      DONE: begin
        Busy      = 1'b1;
        state_nxt = frame_ok ? COLLECT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Software registers; MASK is only sampled into the shadow at frame start.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      en   <= 1'b0;
      sat  <= 1'b0;
      mask <= '0;
    end else begin
      if (wr_ctrl) begin
        en  <= PWData[0];
        sat <= PWData[1];
      end
      if (wr_mask) mask <= PWData[NUM_BANDS-1:0];
    end
  end

  // Frame datapath: shadow mask, band capture, and one band added per SUM cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      active   <= '0;
      captured <= '0;
      band_lat <= '0;
      cnt      <= '0;
      acc      <= '0;
    end else begin
      if ((state_nxt == COLLECT) && (state != COLLECT)) active <= mask;
      case (state)
        COLLECT: begin
          cnt <= '0;
          acc <= '0;
          if (!en) begin
            captured <= '0;
          end else begin
            for (int i = 0; i < NUM_BANDS; i++) begin
              if (hit[i]) band_lat[i] <= BandData[i*DATA_W +: DATA_W];
            end
            captured <= captured | hit;
          end
        end
        SUM: begin
          acc <= acc + addend;
          cnt <= cnt + 1'b1;
        end
        DONE: captured <= '0;
        default: ;
      endcase
    end
  end

  // Current band term and final reduction of the wide accumulator.
  always_comb begin
    addend  = active[cnt] ? ACC_W'($signed(band_lat[cnt])) : '0;
    top     = acc[ACC_W-1 -: TOP_W];
    ovf_nxt = !((&top) || !(|top));
    sum_red = acc[DATA_W-1:0];
    if (ovf_nxt && sat) begin
      sum_red = acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // Result publication at the close of DONE; a RESULT read in the strobe cycle does not consume it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      SumData  <= '0;
      SumValid <= 1'b0;
      ovf      <= 1'b0;
      ready    <= 1'b0;
    end else begin
      SumValid <= (state == DONE);
      if (state == DONE) begin
        SumData <= sum_red;
        ovf     <= ovf_nxt;
        ready   <= 1'b1;
      end else if (rd_result && !SumValid) begin
        ready <= 1'b0;
      end
    end
  end

  // Sticky error flags; a new event beats a clearing STATUS read.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dup  <= 1'b0;
      late <= 1'b0;
    end else begin
      dup  <= dup_evt  | (dup  & ~rd_status);
      late <= late_evt | (late & ~rd_status);
    end
  end

  // Read mux, only driven during the read access phase.
  always_comb begin
    PRData = '0;
    if (rd) begin
      case (PAddr)
        12'h000: PRData = {30'b0, sat, en};
        12'h004: PRData = {{(32-NUM_BANDS){1'b0}}, mask};
        12'h008: PRData = {ready, ovf, {(30-DATA_W){SumData[DATA_W-1]}}, SumData};
        12'h00C: PRData = {dup, late, {(30-NUM_BANDS){1'b0}}, captured};
        default: PRData = '0;
      endcase
    end
  end

endmodule
